// File: rtl/icache_ctrl.sv
// Direct-mapped, one-word-per-block instruction cache with single-word miss refill and one-cycle flush.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_ctrl #(
    parameter int SETS   = 16,
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              imemREN,
    input  logic [ADDR_W-1:0] imemaddr,
    output logic              ihit,
    output logic [ADDR_W-1:0] imemload,
    output logic              iREN,
    output logic [ADDR_W-1:0] iaddr,
    input  logic              iwait,
    input  logic [ADDR_W-1:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);
    // state | meaning
    // IDLE  | serve hits combinationally, detect misses
    // FETCH | read request outstanding for maddr, waiting for iwait=0

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t            state, state_n;
    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  tags [SETS];
    logic [ADDR_W-1:0] data [SETS];
    logic [ADDR_W-1:0] maddr;

    logic [IDX_W-1:0]  req_idx, fill_idx;
    logic [TAG_W-1:0]  req_tag, fill_tag;
    logic              miss, fill;
    logic              unused_addr_bits;

    assign req_idx  = imemaddr[IDX_W+1:2];
    assign req_tag  = imemaddr[ADDR_W-1:IDX_W+2];
    assign fill_idx = maddr[IDX_W+1:2];
    assign fill_tag = maddr[ADDR_W-1:IDX_W+2];
    assign iaddr    = maddr;
    assign unused_addr_bits = ^imemaddr[1:0];

    always_comb begin
        state_n  = state;
        miss     = 1'b0;
        fill     = 1'b0;
        ihit     = 1'b0;
        imemload = '0;
        iREN     = 1'b0;
        case (state)
            IDLE: begin
                ihit = imemREN && !flush && valid[req_idx] && (tags[req_idx] == req_tag);
                miss = imemREN && !ihit && !flush;
                if (ihit)
                    imemload = data[req_idx];
                if (miss)
                    state_n = FETCH;
            end
            FETCH: begin
                iREN = 1'b1;
                // A flush in the same cycle as the returning word discards it.
                fill = !iwait && !flush;
                if (!iwait)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (flush)
            state_n = IDLE;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            maddr <= '0;
            valid <= '0;
            for (int i = 0; i < SETS; i++) begin
                tags[i] <= '0;
                data[i] <= '0;
            end
        end else begin
            state <= state_n;
            if (flush) begin
                valid <= '0;
                maddr <= '0;
            end else if (miss) begin
                maddr <= {imemaddr[ADDR_W-1:2], 2'b00};
            end
            if (fill) begin
                valid[fill_idx] <= 1'b1;
                tags[fill_idx]  <= fill_tag;
                data[fill_idx]  <= iload;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    // Counters survive flush; only RST clears them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (ihit)
                hit_count <= hit_count + 32'd1;
            if (miss)
                miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed scenarios then randomized traffic,
// checked against a frame-array reference model of the cache.
module tb_icache_ctrl;
    localparam int SETS = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        flush = 1'b0;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = '0;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait = 1'b1;
    logic [31:0] iload = '0;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    icache_ctrl #(.SETS(SETS), .ADDR_W(32)) dut (
        .CLK(CLK), .RST(RST), .flush(flush), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload)
`ifdef ICACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: each frame remembers the full word address it holds.
    logic        m_valid [SETS];
    logic [31:0] m_addr  [SETS];
    logic [31:0] m_data  [SETS];
    logic        m_busy;
    logic [31:0] m_busy_addr;
    logic [31:0] m_last;
    int unsigned m_hits, m_misses;
    logic        e_hit, e_ren;
    logic [31:0] e_load, e_iaddr;

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % SETS);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < SETS; i++) begin
            m_valid[i] = 1'b0;
            m_addr[i]  = '0;
            m_data[i]  = '0;
        end
        m_busy = 1'b0;
        m_busy_addr = '0;
        m_last = '0;
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        imemREN = 1'b1;
        imemaddr = 32'h100;
        flush = 1'b1;
        iwait = 1'b0;
        iload = 32'hFFFF_FFFF;
        @(posedge CLK);
        model_reset();
        #1;
        RST = 1'b0;
        imemREN = 1'b0;
        flush = 1'b0;
        iwait = 1'b1;
    endtask

    // Apply inputs mid-cycle and compare outputs against the model.
    task automatic drive(input logic ren, input logic [31:0] a, input logic fl,
                         input logic w, input logic [31:0] ld);
        logic [31:0] wa;
        int i;
        @(negedge CLK);
        imemREN = ren;
        imemaddr = a;
        flush = fl;
        iwait = w;
        iload = ld;
        #1;
        wa = a & ~32'h3;
        i = idx_of(a);
        if (m_busy) begin
            e_hit = 1'b0;
            e_ren = 1'b1;
            e_iaddr = m_busy_addr;
        end else begin
            e_ren = 1'b0;
            e_iaddr = m_last;
            e_hit = ren && !fl && m_valid[i] && (m_addr[i] == wa);
        end
        e_load = e_hit ? m_data[i] : 32'h0;
        chk("ihit", {31'b0, ihit}, {31'b0, e_hit});
        chk("imemload", imemload, e_load);
        chk("iREN", {31'b0, iREN}, {31'b0, e_ren});
        chk("iaddr", iaddr, e_iaddr);
`ifdef ICACHE_STATS_EN
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_misses);
`endif
    endtask

    task automatic tick();
        int j;
        @(posedge CLK);
        if (e_hit)
            m_hits++;
        if (flush) begin
            for (int i = 0; i < SETS; i++)
                m_valid[i] = 1'b0;
            m_busy = 1'b0;
            m_last = '0;
        end else if (m_busy) begin
            if (!iwait) begin
                j = idx_of(m_busy_addr);
                m_valid[j] = 1'b1;
                m_addr[j] = m_busy_addr;
                m_data[j] = iload;
                m_busy = 1'b0;
            end
        end else if (imemREN && !e_hit) begin
            m_busy = 1'b1;
            m_busy_addr = imemaddr & ~32'h3;
            m_last = m_busy_addr;
            m_misses++;
        end
    endtask

    initial begin
        logic [31:0] a;
        model_reset();
        do_reset();

        // Reset state
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        chk("rst_ihit", {31'b0, ihit}, 32'd0);
        chk("rst_iREN", {31'b0, iREN}, 32'd0);
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_imemload", imemload, 32'h0);
        tick();

        // Cold miss on 0x100, three wait cycles, then refill
        drive(1'b1, 32'h100, 1'b0, 1'b1, 32'h0);
        chk("cold_miss_ihit", {31'b0, ihit}, 32'd0);
        tick();
        repeat (3) begin
            drive(1'b1, 32'h100, 1'b0, 1'b1, 32'h0);
            chk("fetch_iREN", {31'b0, iREN}, 32'd1);
            chk("fetch_iaddr", iaddr, 32'h100);
            tick();
        end
        drive(1'b1, 32'h100, 1'b0, 1'b0, 32'hDEAD_BEEF);
        tick();
        drive(1'b1, 32'h100, 1'b0, 1'b1, 32'h0);
        chk("refill_hit", {31'b0, ihit}, 32'd1);
        chk("refill_load", imemload, 32'hDEAD_BEEF);
        chk("refill_iREN", {31'b0, iREN}, 32'd0);
        tick();
        drive(1'b1, 32'h103, 1'b0, 1'b1, 32'h0);
        chk("byte_offset_hit", {31'b0, ihit}, 32'd1);
        chk("byte_offset_load", imemload, 32'hDEAD_BEEF);
        tick();

        // Conflict: 0x140 shares frame 0 with 0x100
        drive(1'b1, 32'h140, 1'b0, 1'b1, 32'h0);
        chk("conflict_miss", {31'b0, ihit}, 32'd0);
        tick();
        drive(1'b1, 32'h140, 1'b0, 1'b0, 32'h1234_5678);
        tick();
        drive(1'b1, 32'h140, 1'b0, 1'b1, 32'h0);
        chk("conflict_load", imemload, 32'h1234_5678);
        tick();
        drive(1'b1, 32'h100, 1'b0, 1'b1, 32'h0);
        chk("evicted_miss", {31'b0, ihit}, 32'd0);
        tick();
        drive(1'b1, 32'h100, 1'b0, 1'b0, 32'hDEAD_BEEF);
        tick();

        // Address changes while FETCH is outstanding
        drive(1'b1, 32'h200, 1'b0, 1'b1, 32'h0);
        tick();
        drive(1'b1, 32'h204, 1'b0, 1'b1, 32'h0);
        chk("latched_iaddr", iaddr, 32'h200);
        chk("no_hit_in_fetch", {31'b0, ihit}, 32'd0);
        tick();
        drive(1'b1, 32'h204, 1'b0, 1'b0, 32'hAAAA_0200);
        tick();
        drive(1'b1, 32'h204, 1'b0, 1'b1, 32'h0);
        chk("next_addr_miss", {31'b0, ihit}, 32'd0);
        tick();
        drive(1'b1, 32'h204, 1'b0, 1'b0, 32'hBBBB_0204);
        chk("next_addr_iaddr", iaddr, 32'h204);
        tick();
        drive(1'b1, 32'h200, 1'b0, 1'b1, 32'h0);
        chk("latched_fill_load", imemload, 32'hAAAA_0200);
        tick();

        // Flush forces ihit low on a would-be hit
        drive(1'b1, 32'h204, 1'b1, 1'b1, 32'h0);
        chk("flush_blocks_hit", {31'b0, ihit}, 32'd0);
        tick();

        // Flush during FETCH with iwait=0 in the same cycle
        drive(1'b1, 32'h300, 1'b0, 1'b1, 32'h0);
        tick();
        drive(1'b1, 32'h300, 1'b1, 1'b0, 32'hCAFE_F00D);
        tick();
        drive(1'b1, 32'h300, 1'b0, 1'b1, 32'h0);
        chk("post_flush_iREN", {31'b0, iREN}, 32'd0);
        chk("post_flush_iaddr", iaddr, 32'h0);
        chk("discarded_fill_miss", {31'b0, ihit}, 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h1111_1111);
        tick();
        drive(1'b1, 32'h204, 1'b0, 1'b1, 32'h0);
        chk("flushed_line_miss", {31'b0, ihit}, 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h2222_2222);
        tick();

        // Flush and miss together: no fill starts
        drive(1'b1, 32'h500, 1'b1, 1'b1, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        chk("flush_wins_iREN", {31'b0, iREN}, 32'd0);
        tick();

        // Reset overrides an in-flight fill
        drive(1'b1, 32'h700, 1'b0, 1'b1, 32'h0);
        tick();
        do_reset();
        drive(1'b1, 32'h100, 1'b0, 1'b1, 32'h0);
        chk("rst_clears_lines", {31'b0, ihit}, 32'd0);
        tick();
        drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h3333_3333);
        tick();

`ifdef ICACHE_STATS_EN
        do_reset();
        drive(1'b1, 32'h600, 1'b0, 1'b1, 32'h0);
        tick();
        drive(1'b1, 32'h600, 1'b0, 1'b0, 32'h6006_6006);
        tick();
        repeat (5) begin
            drive(1'b1, 32'h600, 1'b0, 1'b1, 32'h0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        chk("stats_hits5", hit_count, 32'd5);
        chk("stats_miss1", miss_count, 32'd1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        chk("stats_flush_hits", hit_count, 32'd5);
        chk("stats_flush_miss", miss_count, 32'd1);
        tick();
        do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        chk("stats_rst_hits", hit_count, 32'd0);
        chk("stats_rst_miss", miss_count, 32'd0);
        tick();
`endif

        // Randomized traffic over a small address pool so hits and conflicts are frequent
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            a = (32'($urandom_range(0, 95)) << 2) | 32'($urandom_range(0, 3));
            drive($urandom_range(0, 9) < 8, a, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 9) < 6, $urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
